// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: HD44780 power-up init plus FIFO-fed RS/EN/DATA write timing on the lcd_* pins
module lcd_write_sequencer #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC = 12,
  parameter int HOLD_CYC = 2,
  parameter int EXEC_CYC = 2000,
  parameter int LONG_CYC = 82000,
  parameter int INIT_GAP_CYC = 210000,
  parameter int POWERUP_CYC = 750000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       bl_on,
  output logic       init_done,
  output logic       busy,
  inout  wire  [7:0] lcd_DATA,
  output logic       lcd_ON,
  output logic       lcd_BLON,
  output logic       lcd_EN,
  output logic       lcd_RS,
  output logic       lcd_RW
);
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int MAXC = max2(max2(max2(POWERUP_CYC, INIT_GAP_CYC), max2(LONG_CYC, EXEC_CYC)),
                             max2(max2(SETUP_CYC, EN_CYC), HOLD_CYC));
  localparam int CW = $clog2(MAXC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] T_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] T_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] T_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] T_EXEC  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] T_LONG  = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] T_GAP   = CW'(INIT_GAP_CYC - 1);
  localparam logic [CW-1:0] T_PWR   = CW'(POWERUP_CYC - 1);
  localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  function automatic logic [7:0] rom(input logic [2:0] i);
    return i == 3'd4 ? 8'h0C : i == 3'd5 ? 8'h01 : i == 3'd6 ? 8'h06 : 8'h38;
  endfunction
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, wait_len;
  logic [2:0] idx, idx_d;
  logic done, done_d, rs_q, rs_d, alive, bl_q, push, pop, expired, fifo_nz;
  logic [7:0] data_q, data_d;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fcnt;
  assign wr_ready = alive && fcnt != FULL;
  assign push = wr_valid && wr_ready;
  assign fifo_nz = fcnt != '0;
  assign expired = cnt == '0;
  // The first init write needs the long settle gap; clear/home need the long execution time.
  assign wait_len = (!done && idx == 3'd0) ? T_GAP :
                    (!rs_q && data_q inside {8'h01, 8'h02, 8'h03}) ? T_LONG : T_EXEC;
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      alive <= 1'b0;
      bl_q <= 1'b0;
    end else begin
      alive <= 1'b1;
      bl_q <= bl_on;
      if (push) mem[wp] <= {wr_rs, wr_data};
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= PWRUP;
      cnt <= T_PWR;
      idx <= '0;
      done <= 1'b0;
      rs_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      done <= done_d;
      rs_q <= rs_d;
      data_q <= data_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt - 1'b1;
    idx_d = idx;
    done_d = done;
    rs_d = rs_q;
    data_d = data_q;
    pop = 1'b0;
    unique case (state)
      PWRUP: if (expired) begin
        state_d = SETUP;
        idx_d = '0;
        rs_d = 1'b0;
        data_d = rom(3'd0);
        cnt_d = T_SETUP;
      end
      IDLE: cnt_d = cnt;
      SETUP: if (expired) begin
        state_d = PULSE;
        cnt_d = T_EN;
      end
      PULSE: if (expired) begin
        state_d = HOLD;
        cnt_d = T_HOLD;
      end
      HOLD: if (expired) begin
        state_d = WAIT;
        cnt_d = wait_len;
      end
      WAIT: if (expired) begin
        state_d = IDLE;
        cnt_d = cnt;
        if (idx == 3'd6) done_d = 1'b1;
        else begin
          state_d = SETUP;
          idx_d = idx + 1'b1;
          rs_d = 1'b0;
          data_d = rom(idx + 1'b1);
          cnt_d = T_SETUP;
        end
      end
      default: state_d = PWRUP;
    endcase
    // Popping straight out of an expiring WAIT keeps back-to-back bytes free of idle cycles.
    if (done && fifo_nz && (state == IDLE || (state == WAIT && expired))) begin
      pop = 1'b1;
      state_d = SETUP;
      {rs_d, data_d} = mem[rp];
      cnt_d = T_SETUP;
    end
  end
  assign lcd_EN = state == PULSE;
  assign lcd_RS = rs_q;
  assign lcd_DATA = data_q;
  assign lcd_RW = 1'b0;
  assign lcd_ON = alive;
  assign lcd_BLON = bl_q;
  assign init_done = done;
  assign busy = state != IDLE || fifo_nz;
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: scoreboard bench; expected LCD writes and their timing come from a queue-based model
module tb_lcd_write_sequencer;
  localparam int SETUP = 2, EN = 3, HOLD = 1, EXEC = 5, LONG = 20, GAP = 30, PWR = 10, DEPTH = 4;
  localparam int BIG = 1 << 30;
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         push;
    int         wt;
    int         idx;
  } ent_t;
  logic clk = 0, rst = 1, wr_valid = 0, wr_rs = 0, bl_on = 0;
  logic [7:0] wr_data = 0;
  logic wr_ready, init_done, busy, lcd_ON, lcd_BLON, lcd_EN, lcd_RS, lcd_RW;
  wire [7:0] lcd_DATA;
  lcd_write_sequencer #(
    .SETUP_CYC(SETUP), .EN_CYC(EN), .HOLD_CYC(HOLD), .EXEC_CYC(EXEC), .LONG_CYC(LONG),
    .INIT_GAP_CYC(GAP), .POWERUP_CYC(PWR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rs(wr_rs),
    .wr_data(wr_data), .bl_on(bl_on), .init_done(init_done), .busy(busy), .lcd_DATA(lcd_DATA),
    .lcd_ON(lcd_ON), .lcd_BLON(lcd_BLON), .lcd_EN(lcd_EN), .lcd_RS(lcd_RS), .lcd_RW(lcd_RW)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  ent_t exp_q[$];
  logic [7:0] init_b [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int init_w [7] = '{GAP, EXEC, EXEC, EXEC, EXEC, LONG, EXEC};
  bit armed = 0, en_prev, plast, bl_prev;
  logic prs;
  logic [7:0] pdata;
  int rst_cyc, last_fall, pw, cur_wait, cur_idx, idle_cyc, done_cyc, width, fall_count = 0;
  task automatic model_reset();
    ent_t e;
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      e.rs = 0; e.d = init_b[i]; e.push = -1; e.wt = init_w[i]; e.idx = i;
      exp_q.push_back(e);
    end
    rst_cyc = cyc; en_prev = 0; prs = 0; pdata = 0; plast = 0; width = 0;
    last_fall = -1000; pw = 0; cur_wait = 0; cur_idx = -1; idle_cyc = BIG; done_cyc = -1;
    armed = 1;
  endtask
  always @(negedge clk) begin : mon
    ent_t e;
    int er, base;
    if (armed) begin
      if ({lcd_RS, lcd_DATA} != {prs, pdata})
        chk("bus_stable", int'(en_prev || lcd_EN || cyc <= last_fall + HOLD), 0);
      if (lcd_EN && !en_prev) begin
        if (exp_q.size() == 0) chk("unexpected_write", int'(lcd_DATA), -1);
        else begin
          e = exp_q.pop_front();
          if (e.idx == 0) er = rst_cyc + PWR + SETUP;
          else begin
            base = last_fall + HOLD + pw + (plast ? 1 : 0);
            if (e.idx < 0 && e.push + 1 > base) base = e.push + 1;
            er = base + SETUP;
          end
          chk("wr_rs", int'(lcd_RS), int'(e.rs));
          chk("wr_data", int'(lcd_DATA), int'(e.d));
          chk("en_rise_cycle", cyc, er);
          cur_wait = e.wt; cur_idx = e.idx; idle_cyc = BIG; width = 0;
        end
      end
      if (lcd_EN) width++;
      if (!lcd_EN && en_prev) begin
        chk("en_width", width, EN);
        last_fall = cyc; pw = cur_wait; plast = cur_idx == 6;
        idle_cyc = cyc + HOLD + cur_wait;
        if (cur_idx == 6) done_cyc = idle_cyc;
        fall_count++;
      end
      chk("busy", int'(busy), int'((exp_q.size() > 0 && exp_q[0].push <= cyc) || cyc < idle_cyc));
      chk("init_done", int'(init_done), int'(done_cyc >= 0 && cyc >= done_cyc));
      chk("lcd_on", int'(lcd_ON), int'(cyc > rst_cyc));
      chk("lcd_rw", int'(lcd_RW), 0);
      chk("lcd_blon", int'(lcd_BLON), int'(cyc == rst_cyc ? 1'b0 : bl_prev));
      en_prev = lcd_EN; prs = lcd_RS; pdata = lcd_DATA; bl_prev = bl_on;
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic rs, input logic [7:0] d);
    ent_t e;
    wr_valid = 1; wr_rs = rs; wr_data = d;
    if (wr_ready) begin
      e.rs = rs; e.d = d; e.push = cyc + 1; e.idx = -1;
      e.wt = (!rs && d >= 8'h01 && d <= 8'h03) ? LONG : EXEC;
      exp_q.push_back(e);
    end
    step(1);
    wr_valid = 0;
  endtask
  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, int'(n < budget), 1);
  endtask
  task automatic do_reset();
    rst = 1;
    step(1);
    model_reset();
    chk("rst_en", int'(lcd_EN), 0);
    chk("rst_rs", int'(lcd_RS), 0);
    chk("rst_data", int'(lcd_DATA), 0);
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    rst = 0;
    step(1);
    chk("ready_after_rst", int'(wr_ready), 1);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bl_on = 1'($urandom_range(0, 1));
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, fc, pop_edge;
    logic [7:0] lw [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("ready_pwrup", int'(wr_ready), int'(i < DEPTH));
      push(1'b1, 8'(8'h30 + i));
    end
    wait_idle(2000, "drain_init");
    chk("init_done_after", int'(init_done), 1);
    push(1'b1, 8'h41);
    wait_idle(200, "drain_41");
    for (int i = 0; i < 4; i++) begin
      push(1'b0, lw[i]);
      push(1'b1, 8'h42);
      wait_idle(200, "drain_long");
    end
    push(1'b1, 8'h61);
    push(1'b1, 8'h62);
    push(1'b1, 8'h63);
    fc = fall_count;
    n = 0;
    while (fall_count == fc && n < 100) begin
      step(1);
      n++;
    end
    chk("fall_61_seen", int'(fall_count != fc), 1);
    pop_edge = last_fall + HOLD + EXEC;
    while (cyc + 1 < pop_edge) step(1);
    chk("ready_pushpop", int'(wr_ready), 1);
    push(1'b1, 8'h64);
    chk("ready_3rd", int'(wr_ready), 1);
    push(1'b1, 8'h65);
    chk("ready_4th", int'(wr_ready), 1);
    push(1'b1, 8'h66);
    chk("ready_full", int'(wr_ready), 0);
    push(1'b1, 8'h67);
    wait_idle(500, "drain_wrap");
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 6));
      push(1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 255)));
    end
    wait_idle(1000, "drain_random");
    push(1'b1, 8'h55);
    push(1'b1, 8'h56);
    push(1'b1, 8'h57);
    n = 0;
    while (!lcd_EN && n < 100) begin
      step(1);
      n++;
    end
    chk("en_before_reset", int'(lcd_EN), 1);
    do_reset();
    wait_idle(2000, "drain_reinit");
    chk("init_done_again", int'(init_done), 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
